// File: rtl/z80_int_controller_if.sv
// rtl/z80_int_controller_if.sv - Z80 CPU-side interrupt bus bundle (/M1, /IORQ, RETI, /INT, IM2 vector)
interface z80_int_controller_if;
    logic       m1_n;
    logic       iorq_n;
    logic       reti;
    logic       int_n;
    logic       vec_oe;
    logic [7:0] vec_out;

    // CPU / bus decoder side
    modport master (
        output m1_n,
        output iorq_n,
        output reti,
        input  int_n,
        input  vec_oe,
        input  vec_out
    );

    // Interrupt controller side
    modport slave (
        input  m1_n,
        input  iorq_n,
        input  reti,
        output int_n,
        output vec_oe,
        output vec_out
    );
endinterface

// File: rtl/z80_int_controller.sv
// rtl/z80_int_controller.sv - Z80 IM2 interrupt controller; optional RETI watchdog via INTC_RETI_TIMEOUT_EN
module z80_int_controller #(
    parameter int          NUM_SRC    = 4,
    parameter bit          RISE_FALLN = 1'b1,
    parameter logic [7:0]  VEC_BASE   = 8'hE0,
    parameter logic [15:0] TIMEOUT    = 16'd4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    irq_src,
    input  logic                  mask_we,
    input  logic [NUM_SRC-1:0]    mask_wdata,
    output logic [NUM_SRC-1:0]    enable,
    output logic [NUM_SRC-1:0]    pending,
    output logic                  timeout,
    z80_int_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK     = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   last_sig_q, last_sig_d;
    logic [NUM_SRC-1:0]   init_q, init_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   enable_q, enable_d;
    logic [2:0]           grant_q, grant_d;
    logic                 int_n_q, int_n_d;
    logic                 vec_oe_q, vec_oe_d;
    logic [7:0]           vec_out_q, vec_out_d;

    logic [NUM_SRC-1:0]   edge_det;
    logic [NUM_SRC-1:0]   req;
    logic [NUM_SRC-1:0]   clr;
    logic [2:0]           win_idx;
    logic                 ack_seen;
    logic                 take_ack;
    logic                 svc_timeout;

    // Edge detection; init_q blocks the very first post-reset cycle so a line
    // already high coming out of reset does not look like an edge.
    always_comb begin
        last_sig_d = irq_src;
        init_d     = '1;
        if (RISE_FALLN) begin
            edge_det = irq_src & ~last_sig_q & init_q;
        end else begin
            edge_det = ~irq_src & last_sig_q & init_q;
        end
    end

    // Fixed-priority pick among enabled pending sources, lowest index wins.
    always_comb begin
        req     = pending_q & enable_q;
        win_idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = i[2:0];
            end
        end
    end

    // Ack strobe and the pending-bit clear for the granted source.
    always_comb begin
        ack_seen = ~bus.m1_n & ~bus.iorq_n;
        take_ack = (state_q == REQ) && ack_seen && (req != '0);
        for (int i = 0; i < NUM_SRC; i++) begin
            clr[i] = take_ack && (win_idx == i[2:0]);
        end
    end

    // Pending bits are sticky; a fresh edge beats a same-cycle clear.
    always_comb begin
        pending_d = (pending_q & ~clr) | edge_det;
        enable_d  = mask_we ? mask_wdata : enable_q;
    end

`ifdef INTC_RETI_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    // Watchdog counter runs only in SERVICE and restarts on each entry.
    always_comb begin
        cnt_d       = 16'd0;
        timeout_d   = timeout_q;
        svc_timeout = 1'b0;
        if (state_q == SERVICE) begin
            if (cnt_q == TIMEOUT - 16'd1) begin
                svc_timeout = ~bus.reti;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        if (svc_timeout) begin
            timeout_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_param;

    // Without the watchdog SERVICE only leaves on RETI.
    always_comb begin
        svc_timeout          = 1'b0;
        unused_timeout_param = ^TIMEOUT;
    end

    assign timeout = 1'b0;
`endif

    // Next-state and registered bus outputs.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        vec_out_d = vec_out_q;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req == '0) begin
                    state_d = IDLE;
                end else if (ack_seen) begin
                    state_d   = ACK;
                    grant_d   = win_idx;
                    vec_out_d = {VEC_BASE[7:4], win_idx, 1'b0};
                end
            end
            ACK: begin
                if (bus.iorq_n) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.reti || svc_timeout) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // /INT goes low only on the second consecutive REQ cycle, which gives
        // the two-clock pending-to-/INT latency and drops it as soon as REQ is left.
        int_n_d  = ~((state_q == REQ) && (state_d == REQ));
        vec_oe_d = (state_d == ACK);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_sig_q <= '0;
            init_q     <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            grant_q    <= 3'd0;
            int_n_q    <= 1'b1;
            vec_oe_q   <= 1'b0;
            vec_out_q  <= VEC_BASE;
        end else begin
            state_q    <= state_d;
            last_sig_q <= last_sig_d;
            init_q     <= init_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            grant_q    <= grant_d;
            int_n_q    <= int_n_d;
            vec_oe_q   <= vec_oe_d;
            vec_out_q  <= vec_out_d;
        end
    end

    assign enable      = enable_q;
    assign pending     = pending_q;
    assign bus.int_n   = int_n_q;
    assign bus.vec_oe  = vec_oe_q;
    assign bus.vec_out = vec_out_q;

endmodule

// File: tb/tb_z80_int_controller.sv
// tb/tb_z80_int_controller.sv - directed self-checking bench for z80_int_controller
module tb_z80_int_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_src;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic [3:0] enable;
    logic [3:0] pending;
    logic       timeout;
    int         errors;
    int         checks;

    z80_int_controller_if bus ();

    z80_int_controller #(
        .NUM_SRC    (4),
        .RISE_FALLN (1'b1),
        .VEC_BASE   (8'hE0),
        .TIMEOUT    (16'd16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .enable     (enable),
        .pending    (pending),
        .timeout    (timeout),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        irq_src     = 4'b0100;
        mask_we     = 1'b0;
        mask_wdata  = 4'h0;
        bus.m1_n    = 1'b1;
        bus.iorq_n  = 1'b1;
        bus.reti    = 1'b0;

        // Reset values, source 2 held high through reset
        step(3);
        chk("rst_int_n", 32'(bus.int_n), 32'h1);
        chk("rst_vec_oe", 32'(bus.vec_oe), 32'h0);
        chk("rst_vec_out", 32'(bus.vec_out), 32'hE0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_enable", 32'(enable), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        rst_n = 1'b1;
        step(3);
        chk("init_no_edge", 32'(pending), 32'h0);
        irq_src = 4'b0000;
        step(1);
        irq_src = 4'b0100;
        step(1);
        chk("edge_src2", 32'(pending), 32'h4);
        chk("masked_int_n", 32'(bus.int_n), 32'h1);

        // Clean restart, then sources 1 and 3 together
        rst_n = 1'b0;
        irq_src = 4'b0000;
        step(1);
        rst_n = 1'b1;
        step(2);
        mask_we = 1'b1;
        mask_wdata = 4'hF;
        step(1);
        mask_we = 1'b0;
        chk("enable_F", 32'(enable), 32'hF);
        irq_src = 4'b1010;
        step(1);
        chk("pend_1010", 32'(pending), 32'hA);
        step(1);
        chk("int_n_lat1", 32'(bus.int_n), 32'h1);
        step(1);
        chk("int_n_lat2", 32'(bus.int_n), 32'h0);
        bus.m1_n = 1'b0;
        bus.iorq_n = 1'b0;
        step(1);
        chk("ack1_vec_oe", 32'(bus.vec_oe), 32'h1);
        chk("ack1_vec_out", 32'(bus.vec_out), 32'hE2);
        chk("ack1_pending", 32'(pending), 32'h8);
        chk("ack1_int_n", 32'(bus.int_n), 32'h1);
        step(1);
        chk("ack1_hold", 32'(bus.vec_oe), 32'h1);
        bus.m1_n = 1'b1;
        bus.iorq_n = 1'b1;
        step(1);
        chk("svc_vec_oe", 32'(bus.vec_oe), 32'h0);
        step(5);
        chk("svc_int_n", 32'(bus.int_n), 32'h1);
        bus.reti = 1'b1;
        step(1);
        bus.reti = 1'b0;
        chk("reti_idle", 32'(bus.int_n), 32'h1);
        step(1);
        chk("reti_req", 32'(bus.int_n), 32'h1);
        step(1);
        chk("reti_int_n", 32'(bus.int_n), 32'h0);
        bus.m1_n = 1'b0;
        bus.iorq_n = 1'b0;
        step(1);
        chk("ack2_vec_out", 32'(bus.vec_out), 32'hE6);
        chk("ack2_pending", 32'(pending), 32'h0);
        bus.m1_n = 1'b1;
        bus.iorq_n = 1'b1;
        irq_src = 4'b1011;
        step(1);
        chk("svc2_pending", 32'(pending), 32'h1);
        step(20);
`ifdef INTC_RETI_TIMEOUT_EN
        chk("wd_timeout", 32'(timeout), 32'h1);
        chk("wd_int_n", 32'(bus.int_n), 32'h0);
`else
        chk("no_wd_timeout", 32'(timeout), 32'h0);
        chk("no_wd_int_n", 32'(bus.int_n), 32'h1);
`endif

        // Masked source, enable write later
        rst_n = 1'b0;
        irq_src = 4'b0000;
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("rst2_pending", 32'(pending), 32'h0);
        irq_src = 4'b0001;
        step(1);
        chk("pend_src0", 32'(pending), 32'h1);
        step(3);
        chk("masked_idle", 32'(bus.int_n), 32'h1);
        mask_we = 1'b1;
        mask_wdata = 4'h1;
        step(1);
        mask_we = 1'b0;
        chk("enable_1", 32'(enable), 32'h1);
        step(1);
        chk("unmask_lat1", 32'(bus.int_n), 32'h1);
        step(1);
        chk("unmask_lat2", 32'(bus.int_n), 32'h0);
        mask_we = 1'b1;
        mask_wdata = 4'h0;
        step(1);
        mask_we = 1'b0;
        step(1);
        chk("remask_int_n", 32'(bus.int_n), 32'h1);
        chk("remask_pending", 32'(pending), 32'h1);

        // Reset while in ACK
        mask_we = 1'b1;
        mask_wdata = 4'h1;
        step(1);
        mask_we = 1'b0;
        step(2);
        chk("pre_ack_int_n", 32'(bus.int_n), 32'h0);
        bus.m1_n = 1'b0;
        bus.iorq_n = 1'b0;
        step(1);
        chk("ack3_vec_oe", 32'(bus.vec_oe), 32'h1);
        chk("ack3_vec_out", 32'(bus.vec_out), 32'hE0);
        rst_n = 1'b0;
        irq_src = 4'b0000;
        bus.m1_n = 1'b1;
        bus.iorq_n = 1'b1;
        step(1);
        chk("rstack_vec_oe", 32'(bus.vec_oe), 32'h0);
        chk("rstack_int_n", 32'(bus.int_n), 32'h1);
        chk("rstack_pending", 32'(pending), 32'h0);
        chk("rstack_enable", 32'(enable), 32'h0);
        rst_n = 1'b1;
        step(2);

        // Ack in IDLE ignored
        bus.m1_n = 1'b0;
        bus.iorq_n = 1'b0;
        step(1);
        chk("idle_ack_vec_oe", 32'(bus.vec_oe), 32'h0);
        bus.m1_n = 1'b1;
        bus.iorq_n = 1'b1;
        step(1);

        // Stray RETI in REQ, then edge racing the ack clear
        mask_we = 1'b1;
        mask_wdata = 4'hF;
        step(1);
        mask_we = 1'b0;
        irq_src = 4'b0010;
        step(1);
        irq_src = 4'b0000;
        step(2);
        chk("req_int_n", 32'(bus.int_n), 32'h0);
        bus.reti = 1'b1;
        step(1);
        bus.reti = 1'b0;
        chk("stray_reti", 32'(bus.int_n), 32'h0);
        irq_src = 4'b0010;
        bus.m1_n = 1'b0;
        bus.iorq_n = 1'b0;
        step(1);
        chk("race_pending", 32'(pending), 32'h2);
        chk("race_vec_out", 32'(bus.vec_out), 32'hE2);
        chk("race_vec_oe", 32'(bus.vec_oe), 32'h1);
        bus.m1_n = 1'b1;
        bus.iorq_n = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
